// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the ALU responder: FSM state
//               encoding and the operation-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Responder control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation select encoding
    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SUB = 2'b11;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/likeALU.sv
`default_nettype none
// ============================================================================
// Module      : likeALU
// Description : Purely combinational AND / OR / ADD / SUB unit. Sum and
//               difference are modulo 2^WIDTH; carry and borrow are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module likeALU
    import alu_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_result
);

    // Select one of the four operations
    always_comb begin
        o_result = '0;
        case (i_sel)
            SEL_AND: o_result = i_a & i_b;
            SEL_OR:  o_result = i_a | i_b;
            SEL_ADD: o_result = i_a + i_b;
            SEL_SUB: o_result = i_a - i_b;
            default: o_result = '0;
        endcase
    end

endmodule : likeALU
`default_nettype wire

// File: rtl/alu_responder.sv
`default_nettype none
// ============================================================================
// Module      : alu_responder
// Description : Request/response wrapper around likeALU. A request accepted in
//               IDLE is executed in EXEC from latched operands and presented
//               in RESP until the initiator takes it. Counts completions.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_responder
    import alu_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [1:0]       rsp_sel,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_rsp_sel;
    logic             r_zero;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_alu;

    // The ALU only ever sees latched operands, so req_* never reaches rsp_*
    likeALU #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sel    (r_sel),
        .o_result (w_alu)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = EXEC;
            end
            EXEC: w_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand latch, result register and completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sel     <= SEL_AND;
            r_result  <= '0;
            r_rsp_sel <= SEL_AND;
            r_zero    <= 1'b1;
            r_count   <= '0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_a   <= req_a;
                r_b   <= req_b;
                r_sel <= req_sel;
            end
            if (r_state == EXEC) begin
                r_result  <= w_alu;
                r_rsp_sel <= r_sel;
                r_zero    <= (w_alu == '0);
            end
            if (r_state == RESP && rsp_ready) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign rsp_result = r_result;
    assign rsp_sel    = r_rsp_sel;
    assign rsp_zero   = r_zero;
    assign op_count   = r_count;

endmodule : alu_responder
`default_nettype wire
